// File: rtl/jr_redirect_unit.sv
// Return-address stack with JR misprediction redirect/flush sequencing.
// Optional build macro JR_REDIRECT_STATS_EN adds a saturating mispredict counter.
module jr_redirect_unit #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              jal_valid,
  input  logic [ADDR_W-1:0] jal_pc,
  input  logic              jr_valid,
  input  logic [ADDR_W-1:0] jr_rs_value,
  output logic [ADDR_W-1:0] pred_pc,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_ifid,
  output logic              ras_empty,
  output logic              ras_full
`ifdef JR_REDIRECT_STATS_EN
  ,
  output logic [15:0]       mispredict_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REDIRECT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, top_idx, wr_idx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        state_q, state_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [ADDR_W-1:0] top_val, push_val;
  logic              empty, full, pop_en, push_en;

  // ptr_q is the next free slot; the top entry sits one below it
  assign top_idx  = ptr_q - PTR_W'(1);
  assign top_val  = mem_q[top_idx];
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign push_val = jal_pc + ADDR_W'(4);

  assign pred_pc        = empty ? '0 : top_val;
  assign ras_empty      = empty;
  assign ras_full       = full;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_ifid     = flush_q;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    redirect_pc_d = redirect_pc_q;
    pop_en        = 1'b0;
    push_en       = 1'b0;
    wr_idx        = ptr_q;
    if (!stall) begin
      case (state_q)
        IDLE: begin
          pop_en  = jr_valid && !empty;
          push_en = jal_valid;
          if (jr_valid && (empty || (top_val != jr_rs_value))) begin
            state_d       = REDIRECT;
            redirect_pc_d = jr_rs_value;
          end
        end
        REDIRECT: state_d = FLUSH;
        default:  state_d = IDLE;
      endcase
      // pop-then-push in one cycle replaces the top entry in place
      if (pop_en && push_en) begin
        wr_idx = top_idx;
      end else if (pop_en) begin
        ptr_d = top_idx;
        cnt_d = cnt_q - CNT_W'(1);
      end else if (push_en) begin
        ptr_d = ptr_q + PTR_W'(1);
        if (!full) cnt_d = cnt_q + CNT_W'(1);
      end
    end
    redirect_valid_d = (state_d == REDIRECT);
    flush_d          = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      ptr_q            <= '0;
      cnt_q            <= '0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // Entries are only visible through cnt_q, so they carry no reset
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_idx] <= push_val;
  end

`ifdef JR_REDIRECT_STATS_EN
  logic [15:0] mis_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_cnt_q <= '0;
    end else if ((state_q == IDLE) && (state_d == REDIRECT) && (mis_cnt_q != 16'hFFFF)) begin
      mis_cnt_q <= mis_cnt_q + 16'd1;
    end
  end

  assign mispredict_cnt = mis_cnt_q;
`endif

endmodule
